// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg
//   Shared constants for the register file / scoreboard slice. The
//   writeback and decode stages use the same definitions.
//   No ports (package).
//   Related build option: REGFILE_BYPASS_EN (selects write-through reads
//   and retire-aware stall in the importing modules).
package regfile_scoreboard_pkg;

  localparam int XLEN      = 32;
  localparam int NREGS     = 32;
  localparam int REG_IDX_W = 5;

  // Index of the hardwired-zero register x0.
  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_scoreboard_reg_scoreboard.sv
// reg_scoreboard
//   Per-register busy bits for in-flight producers, plus the decode stall
//   equation.
//   Ports:
//     clk, rst_n        clock, async active-low reset
//     issue_valid       decode issues an instruction this cycle
//     issue_rd          destination of the issued instruction (0 = none)
//     wb_en, wb_rd      writeback retire (clears the busy bit)
//     flush             clears every busy bit, suppresses same-cycle set
//     rs1, rs2          decode source indices
//     stall             a source of the current decode is still in flight
//   Build option REGFILE_BYPASS_EN: a source retiring this cycle does not
//   stall (its data is forwarded by the register file read port).
module reg_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [REG_IDX_W-1:0] issue_rd,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic                 flush,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  output logic                 stall
);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_next_s;
  logic [NREGS-1:0] busy_eff_s;
  logic             rs1_busy_s;
  logic             rs2_busy_s;

  // Next busy vector: flush dominates; otherwise clear then set, so a set
  // to the same index wins (the younger producer owns the register).
  always_comb begin
    busy_next_s = busy_r;
    if (flush) begin
      busy_next_s = '0;
    end else begin
      if (wb_en && (wb_rd != REG_ZERO)) begin
        busy_next_s[wb_rd] = 1'b0;
      end else begin
        busy_next_s = busy_next_s;
      end
      if (issue_valid && (issue_rd != REG_ZERO)) begin
        busy_next_s[issue_rd] = 1'b1;
      end else begin
        busy_next_s = busy_next_s;
      end
    end
  end

  // Busy vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= '0;
    end else begin
      busy_r <= busy_next_s;
    end
  end

  // Effective busy as seen by decode this cycle.
  always_comb begin
    busy_eff_s = busy_r;
`ifdef REGFILE_BYPASS_EN
    if (wb_en && (wb_rd != REG_ZERO)) begin
      busy_eff_s[wb_rd] = 1'b0;
    end else begin
      busy_eff_s = busy_r;
    end
`endif
  end

  // Stall is purely combinational; decode must drop issue_valid itself.
  always_comb begin
    rs1_busy_s = (rs1 != REG_ZERO) && busy_eff_s[rs1];
    rs2_busy_s = (rs2 != REG_ZERO) && busy_eff_s[rs2];
    stall      = issue_valid && (rs1_busy_s || rs2_busy_s);
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   32 x 32-bit architectural register file (x0 reads as zero) with a
//   busy scoreboard for decode operand stalls.
//   Ports:
//     clk, rst_n                      clock, async active-low reset
//     RegWrite, WriteReg, WriteData   writeback write port
//     ReadReg1/2 -> ReadData1/2       combinational decode read ports
//     IssueValid, IssueRd             decode issue (sets busy on IssueRd)
//     Flush                           clears all busy bits
//     Stall                           a decode source is still in flight
//   Build option REGFILE_BYPASS_EN: same-cycle write-through on the read
//   ports and retire-aware stall; when undefined, reads see the old value
//   until the next edge.
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RegWrite,
  input  logic [REG_IDX_W-1:0] WriteReg,
  input  logic [XLEN-1:0]      WriteData,
  input  logic [REG_IDX_W-1:0] ReadReg1,
  input  logic [REG_IDX_W-1:0] ReadReg2,
  output logic [XLEN-1:0]      ReadData1,
  output logic [XLEN-1:0]      ReadData2,
  input  logic                 IssueValid,
  input  logic [REG_IDX_W-1:0] IssueRd,
  input  logic                 Flush,
  output logic                 Stall
);

  logic [XLEN-1:0] regs_r [NREGS];
  logic            wr_en_s;

  assign wr_en_s = RegWrite && (WriteReg != REG_ZERO);

  // Register array; x0 is never written so it stays zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (wr_en_s) begin
      regs_r[WriteReg] <= WriteData;
    end
  end

  // Read port 1 mux.
  always_comb begin
    ReadData1 = regs_r[ReadReg1];
    if (ReadReg1 == REG_ZERO) begin
      ReadData1 = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (wr_en_s && (WriteReg == ReadReg1)) begin
      ReadData1 = WriteData;
`endif
    end else begin
      ReadData1 = regs_r[ReadReg1];
    end
  end

  // Read port 2 mux.
  always_comb begin
    ReadData2 = regs_r[ReadReg2];
    if (ReadReg2 == REG_ZERO) begin
      ReadData2 = '0;
`ifdef REGFILE_BYPASS_EN
    end else if (wr_en_s && (WriteReg == ReadReg2)) begin
      ReadData2 = WriteData;
`endif
    end else begin
      ReadData2 = regs_r[ReadReg2];
    end
  end

  reg_scoreboard u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (IssueValid),
    .issue_rd    (IssueRd),
    .wb_en       (RegWrite),
    .wb_rd       (WriteReg),
    .flush       (Flush),
    .rs1         (ReadReg1),
    .rs2         (ReadReg2),
    .stall       (Stall)
  );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//   Directed stimulus; each cycle's expected outputs go into a queue and a
//   negedge monitor pops and compares them against the DUT.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        IssueValid;
  logic [4:0]  IssueRd;
  logic        Flush;
  logic        Stall;

  typedef struct {
    int          kind;  // 0: ReadData1, 1: ReadData2, 2: Stall
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_scoreboard dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .IssueValid (IssueValid),
    .IssueRd    (IssueRd),
    .Flush      (Flush),
    .Stall      (Stall)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input int kind, input logic [31:0] val, input string name);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    q.push_back(e);
  endtask

  // Advance to just after the next rising edge and return inputs to idle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    RegWrite   = 1'b0;
    WriteReg   = 5'd0;
    WriteData  = 32'd0;
    ReadReg1   = 5'd0;
    ReadReg2   = 5'd0;
    IssueValid = 1'b0;
    IssueRd    = 5'd0;
    Flush      = 1'b0;
  endtask

  // Monitor: compares every expectation queued for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.kind)
        0:       act = ReadData1;
        1:       act = ReadData2;
        default: act = {31'd0, Stall};
      endcase
      n_total++;
      if (act === e.val) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got 0x%08h, expected 0x%08h", e.name, act, e.val);
      end
    end
  end

  initial begin
    rst_n      = 1'b0;
    RegWrite   = 1'b0;
    WriteReg   = 5'd0;
    WriteData  = 32'd0;
    ReadReg1   = 5'd0;
    ReadReg2   = 5'd0;
    IssueValid = 1'b0;
    IssueRd    = 5'd0;
    Flush      = 1'b0;

    // Reset state.
    next_cycle();
    ReadReg1 = 5'd1; ReadReg2 = 5'd31; IssueValid = 1'b1;
    push_exp(0, 32'd0, "reset_rd1");
    push_exp(1, 32'd0, "reset_rd2");
    push_exp(2, 32'd0, "reset_stall");
    next_cycle();
    rst_n = 1'b1;

    // Write x5 and read it in the same cycle.
    next_cycle();
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF; ReadReg1 = 5'd5;
    push_exp(0, BYP ? 32'hDEADBEEF : 32'd0, "x5_same_cycle");
    // Read x5 back, and mark it busy.
    next_cycle();
    ReadReg1 = 5'd5; IssueValid = 1'b1; IssueRd = 5'd5;
    push_exp(0, 32'hDEADBEEF, "x5_readback");
    push_exp(2, 32'd0, "x5_not_yet_busy");
    // Mid-run async reset: data and busy vanish without an edge.
    next_cycle();
    rst_n = 1'b0; ReadReg1 = 5'd5; IssueValid = 1'b1;
    push_exp(0, 32'd0, "midrst_x5");
    push_exp(2, 32'd0, "midrst_stall");
    next_cycle();
    rst_n = 1'b1;
    ReadReg1 = 5'd5;
    push_exp(0, 32'd0, "postrst_x5");

    // x0 stays zero.
    next_cycle();
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h1234; ReadReg1 = 5'd0;
    push_exp(0, 32'd0, "x0_write_cycle");
    next_cycle();
    ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    push_exp(0, 32'd0, "x0_rd1");
    push_exp(1, 32'd0, "x0_rd2");

    // Basic write / next-cycle read; write to non-busy reg leaves it idle.
    next_cycle();
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'hA5A5A5A5;
    next_cycle();
    ReadReg2 = 5'd7; IssueValid = 1'b1;
    push_exp(1, 32'hA5A5A5A5, "x7_read");
    push_exp(2, 32'd0, "x7_not_busy");

    // Same-cycle bypass on a busy register.
    next_cycle();
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h22;
    next_cycle();
    IssueValid = 1'b1; IssueRd = 5'd3;
    next_cycle();
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'h11;
    IssueValid = 1'b1; ReadReg1 = 5'd3;
    push_exp(0, BYP ? 32'h11 : 32'h22, "bypass_data");
    push_exp(2, BYP ? 32'd0 : 32'd1, "bypass_stall");
    next_cycle();
    IssueValid = 1'b1; ReadReg1 = 5'd3;
    push_exp(0, 32'h11, "x3_after");
    push_exp(2, 32'd0, "x3_after_stall");

    // Scoreboard stall on x9 and its release.
    next_cycle();
    IssueValid = 1'b1; IssueRd = 5'd9;
    next_cycle();
    IssueValid = 1'b1; ReadReg1 = 5'd9;
    push_exp(2, 32'd1, "x9_busy");
    next_cycle();
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h99;
    IssueValid = 1'b1; ReadReg2 = 5'd9;
    push_exp(2, BYP ? 32'd0 : 32'd1, "x9_retire_cycle");
    next_cycle();
    IssueValid = 1'b1; ReadReg2 = 5'd9;
    push_exp(2, 32'd0, "x9_released");
    push_exp(1, 32'h99, "x9_data");

    // Set/clear collision on x4: set wins.
    next_cycle();
    IssueValid = 1'b1; IssueRd = 5'd4;
    RegWrite = 1'b1; WriteReg = 5'd4; WriteData = 32'h44;
    next_cycle();
    IssueValid = 1'b1; ReadReg1 = 5'd4;
    push_exp(2, 32'd1, "collision_x4");
    // Set x10 and clear x4 in the same cycle: both take effect.
    next_cycle();
    RegWrite = 1'b1; WriteReg = 5'd4; WriteData = 32'h45;
    IssueValid = 1'b1; IssueRd = 5'd10;
    next_cycle();
    IssueValid = 1'b1; ReadReg1 = 5'd4;
    push_exp(2, 32'd0, "diff_idx_x4_clear");
    next_cycle();
    IssueValid = 1'b1; ReadReg2 = 5'd10;
    push_exp(2, 32'd1, "diff_idx_x10_set");

    // Flush: busy x2 and x6, then flush with an issue to x8 and a writeback.
    next_cycle();
    IssueValid = 1'b1; IssueRd = 5'd2;
    next_cycle();
    IssueValid = 1'b1; IssueRd = 5'd6;
    next_cycle();
    Flush = 1'b1; IssueValid = 1'b1; IssueRd = 5'd8; ReadReg1 = 5'd2;
    RegWrite = 1'b1; WriteReg = 5'd11; WriteData = 32'hBB;
    push_exp(2, 32'd1, "flush_cycle_x2_busy");
    next_cycle();
    IssueValid = 1'b1; ReadReg1 = 5'd2; ReadReg2 = 5'd6;
    push_exp(2, 32'd0, "flush_x2_x6");
    next_cycle();
    IssueValid = 1'b1; ReadReg1 = 5'd8; ReadReg2 = 5'd10;
    push_exp(2, 32'd0, "flush_x8_x10");
    next_cycle();
    ReadReg2 = 5'd11;
    push_exp(1, 32'hBB, "flush_wb_data");

    next_cycle();
    @(negedge clk);
    #1;
    n_total++;
    if (q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
